instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the opcode decoder: turns a mnemonic code plus register and immediate fields into a 32-bit MIPS instruction word.
- Writes each word into instruction memory at an auto-incrementing word address.
- Used by the boot/test loader to fill IMEM before the core is released; the opcodes it emits are exactly those the core's control decode understands.

Parameters:
- ADDR_W, 8, IMEM word-address width; capacity = 2**ADDR_W words.
- BASE_ADDR, 0, first word address written after reset or clear; must be < 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous; rewinds pointer and count
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_kind  input  4  mnemonic: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 addi, 7 slti, 8 andi, 9 ori, 10 xori, 11 lw, 12 sw, 13 beq, 14 j, 15 nop
- in_rs, in_rt, in_rd  input  5 each  register fields
- in_imm  input  16  immediate / branch offset
- in_target  input  26  jump target
- imem_we  output  1  one-cycle write strobe
- imem_addr  output  ADDR_W  word address
- imem_wdata  output  32  encoded word
- count  output  ADDR_W+1  words written since reset/clear
- full  output  1  high when the pointer has passed the last word

Behaviour:
- Encoding, with fields outside the format ignored:
  - R-type (0-5): {6'h00, rs, rt, rd, 5'b0, funct}. funct: add 20, sub 22, and 24, or 25, xor 26, slt 2A (hex).
  - I-type: {op, rs, rt, imm}. op: addi 08, slti 0A, andi 0C, ori 0D, xori 0E, lw 23, sw 2B, beq 04.
  - j: {6'h02, target}.
  - nop: 32'h0.
- FSM states: IDLE, WRITE (plus RD_REQ and RD_CHK under the optional feature).
- IDLE:
  - in_ready = !full && !clear.
  - On accept, the encoded word and current pointer are latched; next state is WRITE.
- WRITE:
  - imem_we = 1 for exactly one cycle; imem_addr and imem_wdata are the latched values; in_ready = 0.
  - On exit, pointer += 1 and count += 1; next state is IDLE.
- Throughput is one instruction per 2 cycles. Latency is accept at edge N, write strobe during cycle N+1.
- imem_we, imem_addr and imem_wdata are registered. imem_addr and imem_wdata hold their last values when imem_we = 0.
- Full: full = 1 when pointer == 2**ADDR_W, i.e. the last written word was the top address. No wrap-around. in_ready stays 0 until clear or reset.
- clear:
  - Pointer returns to BASE_ADDR, count to 0, full to 0, FSM to IDLE.
  - If clear arrives in WRITE, the pending write is suppressed (imem_we = 0 that cycle) and count is not incremented.
  - clear has priority over a simultaneous in_valid; nothing is accepted.
- Reset (rst_n = 0, any time, including mid-WRITE):
  - Immediately imem_we = 0, in_ready = 0, imem_addr = BASE_ADDR, imem_wdata = 0, count = 0, full = 0, state IDLE.
  - in_ready rises in the first cycle after rst_n deasserts.
- in_* fields may change freely while in_ready = 0; only values present at the accept edge matter.

Optional Feature:
- Macro: ENC_READBACK_EN.
- With it defined:
  - Adds ports imem_re (output 1), imem_rdata (input 32, valid one cycle after imem_re) and verify_err (output 1, reset 0).
  - After WRITE, the FSM goes to RD_REQ: imem_re = 1 with the same address.
  - It then goes to RD_CHK, where imem_rdata is compared with the latched word. A mismatch sets verify_err sticky until clear or reset.
  - Pointer and count update on leaving RD_CHK. Throughput becomes 1 per 4 cycles.
  - clear in RD_REQ or RD_CHK aborts the check and leaves verify_err cleared.
- Without it: those ports and states do not exist; 2-cycle throughput as above.

Test Plan:
- Reset, then accept add rs=1 rt=2 rd=3 -> one cycle later imem_we=1, imem_addr=0, imem_wdata=32'h00221820; count=1.
- Back-to-back: addi rs=0 rt=8 imm=5, lw rs=29 rt=9 imm=4, beq rs=1 rt=2 imm=FFFF, j target=10h -> words 20080005, 8FA90004, 1022FFFF, 08000010 at addresses 1-4; in_ready low in every WRITE cycle.
- ADDR_W=2, BASE_ADDR=0, in_valid held high with 5 nops -> 4 writes to addresses 0-3; then full=1, count=4, in_ready=0, 5th request never accepted. Then pulse clear -> full=0, count=0, next write to address 0.
- clear asserted in the WRITE cycle of sw rs=0 rt=1 imm=0 -> no imem_we pulse, count unchanged; a following request writes to BASE_ADDR.
- rst_n dropped asynchronously mid-WRITE -> imem_we falls without waiting for a clock edge; after release count=0, in_ready=1 the next cycle.
- ENC_READBACK_EN: memory model corrupts bit 0 on readback of ori rs=1 rt=1 imm=00FF (34210 0FF) -> imem_re pulses the cycle after imem_we, verify_err=1 two cycles after the write; a clean readback leaves verify_err=0.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Request channel of instr_encoder_loader: mnemonic, register/immediate fields
// and the valid/ready handshake.
interface instr_encoder_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes mnemonic + fields into 32-bit MIPS words and writes them to IMEM at an
// auto-incrementing address. Define ENC_READBACK_EN to add write-then-verify.
module instr_encoder_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    instr_encoder_loader_if.slave   req,
    output logic                    imem_we,
    output logic [ADDR_W-1:0]       imem_addr,
    output logic [31:0]             imem_wdata,
`ifdef ENC_READBACK_EN
    output logic                    imem_re,
    input  logic [31:0]             imem_rdata,
    output logic                    verify_err,
`endif
    output logic [ADDR_W:0]         count,
    output logic                    full
);

    localparam logic [ADDR_W:0]   BASE_PTR = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);

`ifdef ENC_READBACK_EN
    typedef enum logic [1:0] {IDLE, WRITE, RD_REQ, RD_CHK} state_t;
`else
    typedef enum logic [0:0] {IDLE, WRITE} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       enc_word;
    logic              in_ready;
`ifdef ENC_READBACK_EN
    logic              re_q, re_d;
    logic              err_q, err_d;
`endif

    always_comb begin
        enc_word = '0;
        unique case (req.in_kind)
            4'd0:  enc_word = {6'h00, req.in_rs, req.in_rt, req.in_rd, 5'b0, 6'h20};
            4'd1:  enc_word = {6'h00, req.in_rs, req.in_rt, req.in_rd, 5'b0, 6'h22};
            4'd2:  enc_word = {6'h00, req.in_rs, req.in_rt, req.in_rd, 5'b0, 6'h24};
            4'd3:  enc_word = {6'h00, req.in_rs, req.in_rt, req.in_rd, 5'b0, 6'h25};
            4'd4:  enc_word = {6'h00, req.in_rs, req.in_rt, req.in_rd, 5'b0, 6'h26};
            4'd5:  enc_word = {6'h00, req.in_rs, req.in_rt, req.in_rd, 5'b0, 6'h2A};
            4'd6:  enc_word = {6'h08, req.in_rs, req.in_rt, req.in_imm};
            4'd7:  enc_word = {6'h0A, req.in_rs, req.in_rt, req.in_imm};
            4'd8:  enc_word = {6'h0C, req.in_rs, req.in_rt, req.in_imm};
            4'd9:  enc_word = {6'h0D, req.in_rs, req.in_rt, req.in_imm};
            4'd10: enc_word = {6'h0E, req.in_rs, req.in_rt, req.in_imm};
            4'd11: enc_word = {6'h23, req.in_rs, req.in_rt, req.in_imm};
            4'd12: enc_word = {6'h2B, req.in_rs, req.in_rt, req.in_imm};
            4'd13: enc_word = {6'h04, req.in_rs, req.in_rt, req.in_imm};
            4'd14: enc_word = {6'h02, req.in_target};
            default: enc_word = '0;
        endcase
    end

    // Pointer only reaches 2**ADDR_W after writing the top word, so its MSB is the full flag.
    assign full         = ptr_q[ADDR_W];
    assign count        = count_q;
    assign in_ready     = rst_n && (state_q == IDLE) && !full && !clear;
    assign req.in_ready = in_ready;
    // clear in the strobe cycle cancels the pending access.
    assign imem_we      = we_q && !clear;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
`ifdef ENC_READBACK_EN
    assign imem_re      = re_q && !clear;
    assign verify_err   = err_q;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef ENC_READBACK_EN
        re_d    = 1'b0;
        err_d   = err_q;
`endif
        if (clear) begin
            state_d = IDLE;
            ptr_d   = BASE_PTR;
            count_d = '0;
`ifdef ENC_READBACK_EN
            err_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req.in_valid && in_ready) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        addr_d  = ptr_q[ADDR_W-1:0];
                        wdata_d = enc_word;
                    end
                end
                WRITE: begin
`ifdef ENC_READBACK_EN
                    state_d = RD_REQ;
                    re_d    = 1'b1;
`else
                    state_d = IDLE;
                    ptr_d   = ptr_q + 1'b1;
                    count_d = count_q + 1'b1;
`endif
                end
`ifdef ENC_READBACK_EN
                RD_REQ: state_d = RD_CHK;
                RD_CHK: begin
                    state_d = IDLE;
                    ptr_d   = ptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (imem_rdata != wdata_q) err_d = 1'b1;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= BASE_PTR;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_A;
            wdata_q <= '0;
`ifdef ENC_READBACK_EN
            re_q    <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef ENC_READBACK_EN
            re_q    <= re_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed scenarios plus random
// instructions checked against a table-driven encoding model.
module tb_instr_encoder_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic s_clear = 1'b0;
    always #5 clk = ~clk;

    instr_encoder_loader_if m_if ();
    instr_encoder_loader_if s_if ();

    logic        we, s_we, full, s_full;
    logic [7:0]  addr;
    logic [1:0]  s_addr;
    logic [31:0] wdata, s_wdata;
    logic [8:0]  count;
    logic [2:0]  s_count;
`ifdef ENC_READBACK_EN
    logic        re, s_re, verr, s_verr;
    logic [31:0] rdata;
    logic        corrupt = 1'b0;
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr] ^ {31'b0, corrupt};
    end
`endif

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .req(m_if.slave),
        .imem_we(we), .imem_addr(addr), .imem_wdata(wdata),
`ifdef ENC_READBACK_EN
        .imem_re(re), .imem_rdata(rdata), .verify_err(verr),
`endif
        .count(count), .full(full)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
        .clk(clk), .rst_n(rst_n), .clear(s_clear), .req(s_if.slave),
        .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
`ifdef ENC_READBACK_EN
        .imem_re(s_re), .imem_rdata(32'h0), .verify_err(s_verr),
`endif
        .count(s_count), .full(s_full)
    );

    int checks = 0;
    int failures = 0;
    int exp_ptr = 0;

    logic [5:0] r_funct [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A};
    logic [5:0] i_op    [8] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04};

    function automatic logic [31:0] ref_enc(input int k, input logic [4:0] rs, rt, rd,
                                            input logic [15:0] imm, input logic [25:0] tgt);
        if (k < 6)        return {6'h00, rs, rt, rd, 5'b0, r_funct[k]};
        else if (k < 14)  return {i_op[k-6], rs, rt, imm};
        else if (k == 14) return {6'h02, tgt};
        else              return 32'h0;
    endfunction

    task automatic scramble_fields();
        m_if.in_kind = 4'($urandom);   m_if.in_rs  = 5'($urandom);
        m_if.in_rt   = 5'($urandom);   m_if.in_rd  = 5'($urandom);
        m_if.in_imm  = 16'($urandom);  m_if.in_target = 26'($urandom);
    endtask

    // Starts and ends at a negedge; checks the write strobe, address, data and count.
    task automatic issue(input int k, input logic [4:0] rs, rt, rd, input logic [15:0] imm,
                         input logic [25:0] tgt, input logic [31:0] exp_word, input string tag);
        int guard = 0;
        m_if.in_valid = 1'b1; m_if.in_kind = 4'(k);
        m_if.in_rs = rs; m_if.in_rt = rt; m_if.in_rd = rd;
        m_if.in_imm = imm; m_if.in_target = tgt;
        while (!m_if.in_ready && guard < 20) begin @(negedge clk); guard++; end
        checks++;
        if (guard >= 20) begin
            failures++; $display("FAIL %s accept_timeout in_ready=%b required 1", tag, m_if.in_ready);
        end
        @(posedge clk); #1;
        m_if.in_valid = 1'b0; scramble_fields();
        @(negedge clk);
        checks++;
        if (we !== 1'b1 || addr !== 8'(exp_ptr) || wdata !== exp_word || m_if.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s write we=%b addr=%0d wdata=%h rdy=%b required 1 %0d %h 0",
                     tag, we, addr, wdata, m_if.in_ready, exp_ptr, exp_word);
        end
`ifdef ENC_READBACK_EN
        @(negedge clk);
        checks++;
        if (we !== 1'b0 || re !== 1'b1 || addr !== 8'(exp_ptr)) begin
            failures++;
            $display("FAIL %s rd_req we=%b re=%b addr=%0d required 0 1 %0d", tag, we, re, addr, exp_ptr);
        end
        @(negedge clk);
        @(negedge clk);
`else
        @(negedge clk);
`endif
        exp_ptr++;
        checks++;
        if (we !== 1'b0 || count !== 9'(exp_ptr) || wdata !== exp_word) begin
            failures++;
            $display("FAIL %s after we=%b count=%0d wdata=%h required 0 %0d %h",
                     tag, we, count, wdata, exp_ptr, exp_word);
        end
    endtask

    task automatic test_reset();
        m_if.in_valid = 1'b0; s_if.in_valid = 1'b0; scramble_fields();
        s_if.in_kind = 4'd15; s_if.in_rs = '0; s_if.in_rt = '0; s_if.in_rd = '0;
        s_if.in_imm = '0; s_if.in_target = '0;
        #1;
        checks++;
        if (we !== 1'b0 || m_if.in_ready !== 1'b0 || addr !== 8'd0 || wdata !== 32'h0 ||
            count !== 9'd0 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset_state we=%b rdy=%b addr=%0d wdata=%h count=%0d full=%b required 0 0 0 0 0 0",
                     we, m_if.in_ready, addr, wdata, count, full);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (m_if.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_release in_ready=%b required 1", m_if.in_ready);
        end
        exp_ptr = 0;
    endtask

    task automatic test_first_add();
        issue(0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820, "first_add");
    endtask

    task automatic test_back_to_back();
        issue(6,  5'd0,  5'd8, 5'd0, 16'h0005, 26'h0,  32'h20080005, "b2b_addi");
        issue(11, 5'd29, 5'd9, 5'd0, 16'h0004, 26'h0,  32'h8FA90004, "b2b_lw");
        issue(13, 5'd1,  5'd2, 5'd0, 16'hFFFF, 26'h0,  32'h1022FFFF, "b2b_beq");
        issue(14, 5'd0,  5'd0, 5'd0, 16'h0,    26'h10, 32'h08000010, "b2b_j");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int k = int'($urandom_range(0, 15));
            logic [4:0] rs = 5'($urandom), rt = 5'($urandom), rd = 5'($urandom);
            logic [15:0] imm = 16'($urandom);
            logic [25:0] tgt = 26'($urandom);
            issue(k, rs, rt, rd, imm, tgt, ref_enc(k, rs, rt, rd, imm, tgt), "random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_clear_in_write();
        int guard = 0;
        m_if.in_valid = 1'b1; m_if.in_kind = 4'd12;
        m_if.in_rs = 5'd0; m_if.in_rt = 5'd1; m_if.in_imm = 16'h0;
        while (!m_if.in_ready && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        m_if.in_valid = 1'b0; clear = 1'b1;
        @(negedge clk);
        checks++;
        if (we !== 1'b0) begin
            failures++; $display("FAIL clear_write_suppress imem_we=%b required 0", we);
        end
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        checks++;
        if (we !== 1'b0 || count !== 9'd0 || full !== 1'b0) begin
            failures++;
            $display("FAIL clear_after we=%b count=%0d full=%b required 0 0 0", we, count, full);
        end
        exp_ptr = 0;
        issue(7, 5'd3, 5'd4, 5'd0, 16'h8000, 26'h0, 32'h28648000, "after_clear_slti");
    endtask

    task automatic test_full();
        logic [1:0] seen [$];
        int guard = 0;
        s_if.in_valid = 1'b1; s_if.in_kind = 4'd15;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (s_we) seen.push_back(s_addr);
        end
        checks++;
        if (seen.size() != 4) begin
            failures++; $display("FAIL full_write_count writes=%0d required 4", seen.size());
        end
        for (int j = 0; j < seen.size() && j < 4; j++) begin
            checks++;
            if (seen[j] !== 2'(j)) begin
                failures++; $display("FAIL full_addr[%0d] addr=%0d required %0d", j, seen[j], j);
            end
        end
        checks++;
        if (s_full !== 1'b1 || s_count !== 3'd4 || s_if.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_state full=%b count=%0d rdy=%b required 1 4 0", s_full, s_count, s_if.in_ready);
        end
        s_clear = 1'b1;
        @(posedge clk); #1;
        s_clear = 1'b0;
        @(negedge clk);
        checks++;
        if (s_full !== 1'b0 || s_count !== 3'd0) begin
            failures++; $display("FAIL full_clear full=%b count=%0d required 0 0", s_full, s_count);
        end
        while (!s_we && guard < 10) begin @(negedge clk); guard++; end
        checks++;
        if (s_we !== 1'b1 || s_addr !== 2'd0 || s_wdata !== 32'h0) begin
            failures++;
            $display("FAIL full_rewrite we=%b addr=%0d wdata=%h required 1 0 0", s_we, s_addr, s_wdata);
        end
        s_if.in_valid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

`ifdef ENC_READBACK_EN
    task automatic test_readback();
        corrupt = 1'b1;
        issue(9, 5'd1, 5'd1, 5'd0, 16'h00FF, 26'h0, 32'h342100FF, "rb_corrupt");
        checks++;
        if (verr !== 1'b1) begin
            failures++; $display("FAIL rb_err_set verify_err=%b required 1", verr);
        end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; corrupt = 1'b0; exp_ptr = 0;
        @(negedge clk);
        issue(9, 5'd1, 5'd1, 5'd0, 16'h00FF, 26'h0, 32'h342100FF, "rb_clean");
        checks++;
        if (verr !== 1'b0) begin
            failures++; $display("FAIL rb_err_clean verify_err=%b required 0", verr);
        end
    endtask
`endif

    task automatic test_reset_mid_write();
        int guard = 0;
        m_if.in_valid = 1'b1; m_if.in_kind = 4'd0;
        m_if.in_rs = 5'd1; m_if.in_rt = 5'd2; m_if.in_rd = 5'd3;
        while (!m_if.in_ready && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
        checks++;
        if (we !== 1'b1) begin
            failures++; $display("FAIL midreset_pre imem_we=%b required 1", we);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (we !== 1'b0 || m_if.in_ready !== 1'b0 || count !== 9'd0 || addr !== 8'd0 || wdata !== 32'h0) begin
            failures++;
            $display("FAIL midreset_async we=%b rdy=%b count=%0d addr=%0d wdata=%h required 0 0 0 0 0",
                     we, m_if.in_ready, count, addr, wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (m_if.in_ready !== 1'b1 || count !== 9'd0 || we !== 1'b0) begin
            failures++;
            $display("FAIL midreset_release rdy=%b count=%0d we=%b required 1 0 0", m_if.in_ready, count, we);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_add();
        test_back_to_back();
        test_random();
        test_clear_in_write();
        test_full();
`ifdef ENC_READBACK_EN
        test_readback();
`endif
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
